// File: rtl/a_axi_ctrl_pkg.sv
// Shared definitions for the broadcast AXI-lite control write path
// (broadcaster, per-SLR write sinks and the host-side B responder).
package a_axi_ctrl_pkg;

  localparam int         AXIL_ADDR_WIDTH  = 9;
  localparam int         AXIL_DATA_WIDTH  = 32;
  localparam int         AXIL_STRB_WIDTH  = AXIL_DATA_WIDTH / 8;

  localparam logic [8:0] CTRL_ADDR        = 9'h000;
  localparam logic [8:0] ARG_BASE_DEFAULT = 9'h010;

  typedef struct packed {
    logic [AXIL_ADDR_WIDTH-1:0] addr;
  } axil_aw_t;

  typedef struct packed {
    logic [AXIL_DATA_WIDTH-1:0] data;
    logic [AXIL_STRB_WIDTH-1:0] strb;
  } axil_w_t;

endpackage

// File: rtl/a_axi_skid_hold.sv
// One-entry holding register with full flag. Ready depends only on flops and
// stays high on the commit cycle so a new beat can replace the departing one.
module a_axi_skid_hold #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             commit,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  assign in_ready = ~full | commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      data <= '0;
    end else if (in_valid && in_ready) begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      full <= 1'b1;
      data <= in_data;
    end else if (commit) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/a_axi_write_sink_slr.sv
// Per-SLR endpoint of the broadcast control write path: joins AW and W,
// applies byte-strobed writes to the argument shadow and pulses ap_start.
module a_axi_write_sink_slr
  import a_axi_ctrl_pkg::*;
#(
  parameter int C_S_AXI_CONTROL_ADDR_WIDTH  = 9,
  parameter int C_S_AXI_CONTROL_DATA_WIDTH  = 32,
  parameter int C_S_AXI_CONTROL_WSTRB_WIDTH = 4,
  parameter int NUM_ARGS                    = 8,
  parameter logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0] ARG_BASE =
    C_S_AXI_CONTROL_ADDR_WIDTH'(ARG_BASE_DEFAULT)
) (
  input  logic                                   ap_clk,
  input  logic                                   ap_rst_n,
  input  logic                                   s_axi_control_AWVALID,
  output logic                                   s_axi_control_AWREADY,
  input  logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0]  s_axi_control_AWADDR,
  input  logic                                   s_axi_control_WVALID,
  output logic                                   s_axi_control_WREADY,
  input  logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0]  s_axi_control_WDATA,
  input  logic [C_S_AXI_CONTROL_WSTRB_WIDTH-1:0] s_axi_control_WSTRB,
  output logic [NUM_ARGS*32-1:0]                 args,
  output logic                                   ap_start,
  output logic                                   write_err
);

  localparam int AW    = C_S_AXI_CONTROL_ADDR_WIDTH;
  localparam int IDX_W = AW - 2;
  localparam logic [IDX_W-1:0] CTRL_WORD = IDX_W'(CTRL_ADDR >> 2);
  localparam logic [IDX_W-1:0] BASE_WORD = ARG_BASE[AW-1:2];

  logic                       aw_full;
  logic                       w_full;
  logic                       commit;
  logic [AW-1:0]              aw_q;
  axil_w_t                    w_in;
  axil_w_t                    w_q;
  logic [IDX_W-1:0]           word;
  logic [IDX_W-1:0]           arg_idx;
  logic                       ctrl_hit;
  logic                       arg_hit;
  logic                       unused_addr_lsb;
  logic [NUM_ARGS-1:0][31:0]  args_q;
  logic                       ap_start_q;
  logic                       write_err_q;

  assign commit = aw_full & w_full;
  assign w_in   = '{data: s_axi_control_WDATA, strb: s_axi_control_WSTRB};

  a_axi_skid_hold #(.WIDTH(AW)) u_aw_hold (
    .clk      (ap_clk),
    .rst_n    (ap_rst_n),
    .in_valid (s_axi_control_AWVALID),
    .in_ready (s_axi_control_AWREADY),
    .in_data  (s_axi_control_AWADDR),
    .commit   (commit),
    .full     (aw_full),
    .data     (aw_q)
  );

  a_axi_skid_hold #(.WIDTH($bits(axil_w_t))) u_w_hold (
    .clk      (ap_clk),
    .rst_n    (ap_rst_n),
    .in_valid (s_axi_control_WVALID),
    .in_ready (s_axi_control_WREADY),
    .in_data  (w_in),
    .commit   (commit),
    .full     (w_full),
    .data     (w_q)
  );

  // Byte-lane bits of the address never select anything.
  assign unused_addr_lsb = ^aw_q[1:0];
  assign word     = aw_q[AW-1:2];
  assign arg_idx  = word - BASE_WORD;
  assign ctrl_hit = (word == CTRL_WORD);
  assign arg_hit  = (word >= BASE_WORD) && (32'(arg_idx) < 32'(NUM_ARGS));

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      // NOTE: the argument shadow is reset: kernels read it as defined zeros after reset.
      args_q      <= '0;
      ap_start_q  <= 1'b0;
      write_err_q <= 1'b0;
    end else begin
      ap_start_q  <= commit & ctrl_hit & w_q.strb[0] & w_q.data[0];
      write_err_q <= commit & ~ctrl_hit & ~arg_hit;
      for (int k = 0; k < NUM_ARGS; k++) begin
        for (int i = 0; i < 4; i++) begin
          if (commit && arg_hit && arg_idx == IDX_W'(k) && w_q.strb[i])
            args_q[k][8*i +: 8] <= w_q.data[8*i +: 8];
        end
      end
    end
  end

  assign args      = args_q;
  assign ap_start  = ap_start_q;
  assign write_err = write_err_q;

endmodule
